// File: rtl/mem_read_arbiter_pkg.sv
// Shared types and constants for the cache-refill read arbiter.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package mem_read_arbiter_pkg;

    // Refill block width used by both cache refill paths.
    localparam int CACHE_BLK_SIZE = 128;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_t;

    // Port identifiers, also used as the encoding of the owner/last registers.
    localparam logic ARB_IC = 1'b0;
    localparam logic ARB_DC = 1'b1;

    // Contents of one pending refill request.
    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  ren;
    } rd_req_t;

    // Round-robin pick: on a tie the port that was not granted last wins,
    // otherwise the only pending port wins.
    function automatic logic pick_port(input logic ic_v, input logic dc_v, input logic last);
        if (ic_v && dc_v) begin
            return ~last;
        end
        if (dc_v) begin
            return ARB_DC;
        end
        return ARB_IC;
    endfunction

endpackage

// File: rtl/mem_read_arbiter_req_slot.sv
// One-entry pending request slot for a cache refill port (arb_req_slot).
// Latency: request pulse loads the slot at the next edge; rrdy drops from that edge.
// Backpressure: rrdy=0 while occupied; a request pulse while occupied is dropped.
//
// Ports: cpu_clk/cpu_rstn clock and async active-low reset; ren/raddr request
// pulse from the cache; clr marks the response as delivered; rrdy, pend_v and
// pend expose the slot state to the arbiter.
module arb_req_slot
    import mem_read_arbiter_pkg::*;
(
    input  logic        cpu_clk,
    input  logic        cpu_rstn,
    input  logic [3:0]  ren,
    input  logic [31:0] raddr,
    input  logic        clr,
    output logic        rrdy,
    output logic        pend_v,
    output rd_req_t     pend
);

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            pend_v <= 1'b0;
            pend   <= '0;
        end else if (clr) begin
            pend_v <= 1'b0;
        end else if ((|ren) && !pend_v) begin
            // A pulse while occupied is a protocol error: keep the original request.
            pend_v    <= 1'b1;
            pend.addr <= raddr;
            pend.ren  <= ren;
        end
    end

    assign rrdy = !pend_v;

endmodule

// File: rtl/mem_read_arbiter.sv
// Round-robin arbiter of ICache/DCache block refills onto one memory read port.
// Latency: request pulse to dev_ren >= 2 cycles; dev_rvalid to x_rvalid 1 cycle.
// Backpressure: issue waits for dev_rrdy in IDLE; each port holds one request, rrdy low until its response.
//
// Ports: cpu_clk/cpu_rstn clock and async active-low reset; ic_*/dc_* cache
// request (rrdy/ren/raddr) and response (rvalid/rdata) channels; dev_* the
// single memory read port (rrdy/ren/raddr out, rvalid/rdata back).
module mem_read_arbiter
    import mem_read_arbiter_pkg::*;
#(
    parameter int BLK_W    = CACHE_BLK_SIZE,
    parameter bit RST_PRIO = 1'b0
) (
    input  logic             cpu_clk,
    input  logic             cpu_rstn,
    output logic             ic_rrdy,
    input  logic [3:0]       ic_ren,
    input  logic [31:0]      ic_raddr,
    output logic             ic_rvalid,
    output logic [BLK_W-1:0] ic_rdata,
    output logic             dc_rrdy,
    input  logic [3:0]       dc_ren,
    input  logic [31:0]      dc_raddr,
    output logic             dc_rvalid,
    output logic [BLK_W-1:0] dc_rdata,
    input  logic             dev_rrdy,
    output logic [3:0]       dev_ren,
    output logic [31:0]      dev_raddr,
    input  logic             dev_rvalid,
    input  logic [BLK_W-1:0] dev_rdata
);

    arb_state_t state;
    arb_state_t state_nxt;
    logic       owner;
    logic       last;
    logic       win;
    logic       issue;
    logic       deliver;
    rd_req_t    sel;

    logic       ic_pend_v;
    logic       dc_pend_v;
    rd_req_t    ic_pend;
    rd_req_t    dc_pend;
    logic       ic_clr;
    logic       dc_clr;

    assign ic_clr = deliver && (owner == ARB_IC);
    assign dc_clr = deliver && (owner == ARB_DC);

    arb_req_slot u_ic_slot (
        .cpu_clk  (cpu_clk),
        .cpu_rstn (cpu_rstn),
        .ren      (ic_ren),
        .raddr    (ic_raddr),
        .clr      (ic_clr),
        .rrdy     (ic_rrdy),
        .pend_v   (ic_pend_v),
        .pend     (ic_pend)
    );

    arb_req_slot u_dc_slot (
        .cpu_clk  (cpu_clk),
        .cpu_rstn (cpu_rstn),
        .ren      (dc_ren),
        .raddr    (dc_raddr),
        .clr      (dc_clr),
        .rrdy     (dc_rrdy),
        .pend_v   (dc_pend_v),
        .pend     (dc_pend)
    );

    // In IDLE every pending slot is un-issued: the owner's slot is cleared on
    // the same edge that returns the FSM to IDLE.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        deliver   = 1'b0;
        win       = pick_port(ic_pend_v, dc_pend_v, last);
        sel       = (win == ARB_DC) ? dc_pend : ic_pend;
        if (state == ARB_IDLE) begin
            if ((ic_pend_v || dc_pend_v) && dev_rrdy) begin
                issue     = 1'b1;
                state_nxt = ARB_WAIT;
            end
        end else begin
            if (dev_rvalid) begin
                deliver   = 1'b1;
                state_nxt = ARB_IDLE;
            end
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Registered memory request and response delivery; dev_ren and x_rvalid
    // are single-cycle pulses, address and data hold between transactions.
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            dev_ren   <= '0;
            dev_raddr <= '0;
            owner     <= ARB_IC;
            last      <= ~RST_PRIO;
            ic_rvalid <= 1'b0;
            dc_rvalid <= 1'b0;
            ic_rdata  <= '0;
            dc_rdata  <= '0;
        end else begin
            dev_ren   <= '0;
            ic_rvalid <= 1'b0;
            dc_rvalid <= 1'b0;
            if (issue) begin
                dev_ren   <= sel.ren;
                dev_raddr <= sel.addr;
                owner     <= win;
            end
            if (deliver) begin
                last <= owner;
                if (owner == ARB_IC) begin
                    ic_rvalid <= 1'b1;
                    ic_rdata  <= dev_rdata;
                end else begin
                    dc_rvalid <= 1'b1;
                    dc_rdata  <= dev_rdata;
                end
            end
        end
    end

endmodule
